// File: rtl/boot_loader.sv
// boot_loader: streams a little-endian word image into memory while holding the Cpu in reset,
// then hands the memory port to the Cpu. Optional feature macro: BOOT_CHECKSUM_EN (sum trailer check).
module boot_loader #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        cpu_reset,
  input  logic [31:0] cpu_bus_addr,
  input  logic [31:0] cpu_bus_data_w,
  input  logic [3:0]  cpu_bus_mask_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_w,
  output logic [3:0]  mem_mask_w,
  output logic        busy,
  output logic        error
);

  localparam int unsigned WIDX_W = $clog2(MEM_WORDS + 1);

  // Without the checksum, FLUSH gives the final write its own cycle before the Cpu is released.
  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHECK,
`else
    S_FLUSH,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          byte_idx;
  logic [23:0]         byte_buf;
  logic [WIDX_W-1:0]   word_idx;
  logic [WIDX_W-1:0]   n_words;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic [3:0]          wr_mask;
  logic                accept;
  logic                last_byte;
  logic                word_last;
  logic [31:0]         word;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]         sum;
`endif

  // Byte assembly and next-state selection.
  always_comb begin
    accept     = in_valid && in_ready;
    last_byte  = (byte_idx == 2'd3);
    word       = {in_data, byte_buf};
    word_last  = ((word_idx + WIDX_W'(1)) == n_words);
    state_next = state;
    case (state)
      S_HEADER: begin
        if (accept && last_byte) begin
          if (word > 32'(MEM_WORDS)) begin
            state_next = S_ERROR;
          end else if (word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_RUN;
`endif
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_byte && word_last) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_FLUSH;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (accept && last_byte) begin
          state_next = (word == sum) ? S_RUN : S_ERROR;
        end
      end
`else
      S_FLUSH:  state_next = S_RUN;
`endif
      S_RUN:    state_next = S_RUN;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_ERROR;
    endcase
  end

  // State, counters, write port and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_HEADER;
      byte_idx  <= 2'd0;
      byte_buf  <= 24'd0;
      word_idx  <= '0;
      n_words   <= '0;
      wr_addr   <= 32'd0;
      wr_data   <= 32'd0;
      wr_mask   <= 4'h0;
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b1;
      error     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum       <= 32'd0;
`endif
    end else begin
      state     <= state_next;
`ifdef BOOT_CHECKSUM_EN
      in_ready  <= (state_next == S_HEADER) || (state_next == S_DATA) || (state_next == S_CHECK);
`else
      in_ready  <= (state_next == S_HEADER) || (state_next == S_DATA);
`endif
      cpu_reset <= (state_next != S_RUN);
      busy      <= (state_next != S_RUN);
      error     <= (state_next == S_ERROR);
      wr_mask   <= 4'h0;
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    byte_buf[7:0]   <= in_data;
          2'd1:    byte_buf[15:8]  <= in_data;
          2'd2:    byte_buf[23:16] <= in_data;
          default: ;
        endcase
      end
      if (accept && last_byte) begin
        if ((state == S_HEADER) && (state_next != S_ERROR)) begin
          n_words <= WIDX_W'(word);
        end
        if (state == S_DATA) begin
          wr_addr  <= 32'(BASE_WORD) + 32'(word_idx);
          wr_data  <= word;
          wr_mask  <= 4'hF;
          word_idx <= word_idx + WIDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
          sum      <= sum + word;
`endif
        end
      end
    end
  end

  // Memory port belongs to the loader until RUN, then to the Cpu.
  assign mem_addr   = (state == S_RUN) ? cpu_bus_addr   : wr_addr;
  assign mem_data_w = (state == S_RUN) ? cpu_bus_data_w : wr_data;
  assign mem_mask_w = (state == S_RUN) ? cpu_bus_mask_w : wr_mask;

endmodule
